// File: rtl/mcu_cmd_pkg.sv
// Shared constants, opcodes and FSM state encoding for the MCU command sequencer.
package mcu_cmd_pkg;

    localparam logic [3:0] OP_SYNC_CLK = 4'd1;
    localparam logic [3:0] OP_SAVE_CLK = 4'd2;
    localparam logic [3:0] OP_RUN_ON   = 4'd3;
    localparam logic [3:0] OP_RUN_OFF  = 4'd4;

    localparam logic [3:0] HDR_NIB = 4'hC;
    localparam logic [3:0] CHK_KEY = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OPC,
        ST_CHK,
        ST_GAP
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_SYNC_CLK) || (op == OP_SAVE_CLK) ||
               (op == OP_RUN_ON)   || (op == OP_RUN_OFF);
    endfunction

endpackage

// File: rtl/mcu_lane_mux.sv
// One from_mcu lane: choose the frame nibble while this lane is framed, else coincidence data.
module mcu_lane_mux (
    input  logic       sel,
    input  logic [3:0] frame_nib,
    input  logic [3:0] coin,
    output logic [3:0] lane
);

    assign lane = sel ? frame_nib : coin;

endmodule

// File: rtl/mcu_cmd_sequencer.sv
// Sends HDR/OPC/CHK/GAP command frames onto selected rocstar lanes, passing coincidence
// data through on all other lanes and counting the coincidence nibbles it suppresses.
//
// state | meaning
// IDLE  | ready for a command, every lane passes coin_in through
// HDR   | masked lanes carry the header nibble
// OPC   | masked lanes carry the latched opcode
// CHK   | masked lanes carry opcode ^ check key
// GAP   | masked lanes held at zero for GAPCYC cycles, then repeat or finish
module mcu_cmd_sequencer
    import mcu_cmd_pkg::*;
#(
    parameter int NPORT  = 8,
    parameter int GAPCYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [NPORT-1:0]   cmd_mask,
    input  logic [3:0]         cmd_rep,
    input  logic [4*NPORT-1:0] coin_in,
    output logic [4*NPORT-1:0] lane_out,
    output logic               busy,
    output logic               err_op,
    input  logic               clr_err,
    output logic [15:0]        drop_cnt
);

    localparam int GW = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;
    localparam int CW = $clog2(NPORT + 1);

    state_t             state;
    logic [3:0]         op_q;
    logic [NPORT-1:0]   mask_q;
    logic [3:0]         rep_q;
    logic [GW-1:0]      gap_cnt;
    logic               frame_act;
    logic [3:0]         frame_nib;
    logic [4*NPORT-1:0] coin_q;
    logic               accept;
    logic [CW-1:0]      drop_inc;
    logic [16:0]        drop_sum;

    assign accept = cmd_valid && cmd_ready;

    // frame_act/frame_nib are loaded with the value of the state being entered, so the
    // lane outputs line up with the state register without a combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            frame_act <= 1'b0;
            frame_nib <= 4'd0;
            op_q      <= 4'd0;
            mask_q    <= '0;
            rep_q     <= 4'd0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && op_legal(cmd_op)) begin
                        state     <= ST_HDR;
                        op_q      <= cmd_op;
                        mask_q    <= cmd_mask;
                        rep_q     <= (cmd_rep == 4'd0) ? 4'd1 : cmd_rep;
                        frame_act <= 1'b1;
                        frame_nib <= HDR_NIB;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_HDR: begin
                    state     <= ST_OPC;
                    frame_nib <= op_q;
                end
                ST_OPC: begin
                    state     <= ST_CHK;
                    frame_nib <= op_q ^ CHK_KEY;
                end
                ST_CHK: begin
                    state     <= ST_GAP;
                    frame_nib <= 4'd0;
                    gap_cnt   <= GW'(GAPCYC - 1);
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        if (rep_q > 4'd1) begin
                            state     <= ST_HDR;
                            rep_q     <= rep_q - 4'd1;
                            frame_nib <= HDR_NIB;
                        end else begin
                            state     <= ST_IDLE;
                            frame_act <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    frame_act <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_op <= 1'b0;
        end else if (accept && !op_legal(cmd_op)) begin
            err_op <= 1'b1;
        end else if (clr_err) begin
            err_op <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_q <= '0;
        end else begin
            coin_q <= coin_in;
        end
    end

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (mask_q[i] && (coin_in[4*i +: 4] != 4'd0)) begin
                drop_inc = drop_inc + CW'(1);
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (state != ST_IDLE) begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_lane
        mcu_lane_mux u_mux (
            .sel       (frame_act && mask_q[g]),
            .frame_nib (frame_nib),
            .coin      (coin_q[4*g +: 4]),
            .lane      (lane_out[4*g +: 4])
        );
    end

endmodule

// File: tb/tb_mcu_cmd_sequencer.sv
// Directed scoreboard bench for mcu_cmd_sequencer: stimulus queues the expected outputs of
// every cycle, an independent monitor pops and compares them on the falling edge.
module tb_mcu_cmd_sequencer;

    localparam int NPORT  = 8;
    localparam int GAPCYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [7:0]  cmd_mask = 8'd0;
    logic [3:0]  cmd_rep = 4'd0;
    logic [31:0] coin_in = 32'd0;
    logic [31:0] lane_out;
    logic        busy;
    logic        err_op;
    logic        clr_err = 1'b0;
    logic [15:0] drop_cnt;

    mcu_cmd_sequencer #(.NPORT(NPORT), .GAPCYC(GAPCYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_rep   (cmd_rep),
        .coin_in   (coin_in),
        .lane_out  (lane_out),
        .busy      (busy),
        .err_op    (err_op),
        .clr_err   (clr_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] lane;
        logic        busy;
        logic        ready;
        logic        err;
        logic [15:0] drop;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    logic        e_err = 1'b0;
    logic [15:0] e_drop = 16'd0;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".lane"},  lane_out, e.lane);
            cmp({e.name, ".busy"},  32'(busy), 32'(e.busy));
            cmp({e.name, ".ready"}, 32'(cmd_ready), 32'(e.ready));
            cmp({e.name, ".err"},   32'(err_op), 32'(e.err));
            cmp({e.name, ".drop"},  32'(drop_cnt), 32'(e.drop));
        end
    end

    task automatic tick(input string nm, input logic [31:0] el, input logic eb, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.lane  = el;
        e.busy  = eb;
        e.ready = er;
        e.err   = e_err;
        e.drop  = e_drop;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] compose(input logic [7:0] m, input logic [3:0] nib,
                                            input logic [31:0] coin);
        logic [31:0] r;
        r = coin;
        for (int i = 0; i < 8; i++) if (m[i]) r[4*i +: 4] = nib;
        return r;
    endfunction

    function automatic int hits(input logic [7:0] m, input logic [31:0] coin);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (m[i] && coin[4*i +: 4] != 4'd0) n++;
        return n;
    endfunction

    // Full command with constant coin_in; lane nibbles follow the frame C, op, op^A, 0 x GAPCYC.
    task automatic run_cmd(input string nm, input logic [3:0] op, input logic [7:0] m,
                           input logic [3:0] rep, input logic [31:0] coin);
        int reps;
        int ph;
        int total;
        logic [3:0] nib;
        reps  = (rep == 4'd0) ? 1 : int'(rep);
        total = reps * (3 + GAPCYC);
        coin_in = coin; cmd_op = op; cmd_mask = m; cmd_rep = rep; cmd_valid = 1'b1;
        tick({nm, "_acc"}, compose(m, 4'hC, coin), 1'b1, 1'b0);
        cmd_valid = 1'b0;
        for (int k = 1; k <= total; k++) begin
            e_drop = (int'(e_drop) + hits(m, coin) > 65535) ? 16'hFFFF
                                                           : 16'(int'(e_drop) + hits(m, coin));
            ph = k % (3 + GAPCYC);
            if (k == total) begin
                tick({nm, "_idle"}, coin, 1'b0, 1'b1);
            end else begin
                case (ph)
                    0:       nib = 4'hC;
                    1:       nib = op;
                    2:       nib = op ^ 4'hA;
                    default: nib = 4'h0;
                endcase
                tick({nm, "_frm"}, compose(m, nib, coin), 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d entries left", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        tick("rst0", 32'h0, 1'b0, 1'b0);
        tick("rst1", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick("rel", 32'h0, 1'b0, 1'b1);

        // idle pass-through
        coin_in = 32'h0000_5000;
        tick("s1", 32'h0000_5000, 1'b0, 1'b1);

        // single frame on lane0, rep 0 behaves as 1
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_mask = 8'h01; cmd_rep = 4'd0;
        tick("s2_hdr", 32'h0000_500C, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick("s2_opc", 32'h0000_5001, 1'b1, 1'b0);
        tick("s2_chk", 32'h0000_500B, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick("s2_gap", 32'h0000_5000, 1'b1, 1'b0);
        tick("s2_idle", 32'h0000_5000, 1'b0, 1'b1);

        // three repeats on all lanes
        coin_in = 32'h0;
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_mask = 8'hFF; cmd_rep = 4'd3;
        tick("s3_hdr", 32'hCCCC_CCCC, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) tick("s3_hdr", 32'hCCCC_CCCC, 1'b1, 1'b0);
            tick("s3_opc", 32'h2222_2222, 1'b1, 1'b0);
            tick("s3_chk", 32'h8888_8888, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) tick("s3_gap", 32'h0, 1'b1, 1'b0);
        end
        tick("s3_idle", 32'h0, 1'b0, 1'b1);

        // illegal opcodes and clear priority
        cmd_valid = 1'b1; cmd_op = 4'hC;
        e_err = 1'b1; tick("s4_ill", 32'h0, 1'b0, 1'b1);
        cmd_valid = 1'b0; clr_err = 1'b1;
        e_err = 1'b0; tick("s4_clr", 32'h0, 1'b0, 1'b1);
        clr_err = 1'b0; cmd_valid = 1'b1; cmd_op = 4'hC;
        e_err = 1'b1; tick("s4_ill2", 32'h0, 1'b0, 1'b1);
        cmd_op = 4'h0; clr_err = 1'b1;
        tick("s4_both", 32'h0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        e_err = 1'b0; tick("s4_clr2", 32'h0, 1'b0, 1'b1);
        clr_err = 1'b0;
        tick("s4_quiet", 32'h0, 1'b0, 1'b1);

        // drop counting: 8 lanes x 7 busy cycles = 56
        run_cmd("s5", 4'd3, 8'hFF, 4'd1, 32'h3333_3333);
        if (e_drop != 16'd56) $display("note: drop model %0d", e_drop);

        // drive drop_cnt into saturation with long repeat commands
        for (int c = 0; c < 79; c++) run_cmd("s5_sat", 4'd4, 8'hFF, 4'd15, 32'h3333_3333);

        // reset while in OPC
        coin_in = 32'h0;
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_mask = 8'hFF; cmd_rep = 4'd2;
        tick("s6_hdr", 32'hCCCC_CCCC, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick("s6_opc", 32'h1111_1111, 1'b1, 1'b0);
        rst = 1'b1;
        e_drop = 16'd0;
        tick("s6_rst", 32'h0, 1'b0, 1'b0);
        rst = 1'b0; coin_in = 32'h0000_0007;
        tick("s6_rel", 32'h0000_0007, 1'b0, 1'b1);
        coin_in = 32'h1234_5678;
        tick("s6_pass", 32'h1234_5678, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcu_cmd_sequencer.md
MCU_CMD_SEQUENCER -- requirements
Module: mcu_cmd_sequencer

Interface
REQ-001 Parameter NPORT, default 8: number of rocstar board lanes (A1..A4, B1..B4).
REQ-002 Parameter GAPCYC, default 4: idle cycles forced after each command frame.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request from bus-register logic.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  4  opcode: 1 sync_clk, 2 save_clk, 3 runmode-on, 4 runmode-off; all other values are illegal.
REQ-008 cmd_mask  input  NPORT  per-lane enable; bit i selects lane i.
REQ-009 cmd_rep  input  4  frame repeat count; 0 is treated as 1.
REQ-010 coin_in  input  4*NPORT  coincidence nibbles, lane i at [4i+3:4i]; 0 means idle.
REQ-011 lane_out  output  4*NPORT  nibbles driven to the from_mcu lanes.
REQ-012 busy  output  1  a frame sequence is in progress.
REQ-013 err_op  output  1  sticky flag: illegal opcode offered.
REQ-014 clr_err  input  1  clears err_op.
REQ-015 drop_cnt  output  16  saturating count of suppressed nonzero coincidence nibbles.

Function
REQ-016 A command is accepted on a cycle with cmd_valid & cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-017 States: IDLE, HDR, OPC, CHK, GAP; acceptance of a legal op moves IDLE->HDR and latches op, mask and rep.
REQ-018 Masked lanes SHALL carry 4'hC in HDR, op in OPC, and op^4'hA in CHK, one cycle each.
REQ-019 Masked lanes SHALL carry 0 for GAPCYC cycles in GAP; then HDR if remaining rep > 1 (rep decremented), else IDLE.
REQ-020 Unmasked lanes, and all lanes in IDLE, SHALL pass coin_in through with exactly 1 cycle of latency (registered).
REQ-021 lane_out SHALL be registered: the HDR nibble appears on the cycle after acceptance.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 An illegal op SHALL be consumed (ready handshake completes) without starting a frame, and SHALL set err_op on the following cycle.
REQ-024 clr_err SHALL clear err_op; if an error and clr_err coincide, err_op SHALL be set.
REQ-025 Each cycle, drop_cnt SHALL add the number of masked lanes with nonzero coin_in while not in IDLE (0..NPORT per cycle).
REQ-026 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 A command sequence SHALL NOT be aborted except by rst.
REQ-028 cmd_mask of 0 SHALL still run the full sequence timing with no lane affected.

Reset
REQ-029 While rst is 1: state IDLE, lane_out 0, busy 0, err_op 0, drop_cnt 0, cmd_ready 0.
REQ-030 After rst is released, cmd_ready SHALL be 1 from the first cycle after release.
REQ-031 rst asserted mid-frame SHALL drive all lanes to 0 on the next cycle and discard latched op, mask and rep.

Structure
REQ-032 Package mcu_cmd_pkg SHALL hold the opcode constants, the HDR nibble 4'hC, the CHK key 4'hA, and the state enum.
REQ-033 Sub-module mcu_lane_mux SHALL implement the per-lane select between coin_in and the frame nibble, instantiated NPORT times.
REQ-034 The target size is 120-400 RTL lines, with the FSM, repeat counter, gap counter and popcount saturating adder at top level.

Verification
REQ-035 Scenario 1 -- idle pass-through: coin_in lane3=4'h5 -> lane_out lane3=4'h5 one cycle later; cmd_ready=1, busy=0.
REQ-036 Scenario 2 -- single frame: op=1, mask=8'h01, rep=0 -> lane0 sequence C,1,B,0,0,0,0; busy high 7 cycles; other lanes pass through.
REQ-037 Scenario 3 -- repeat: op=2, mask=8'hFF, rep=3 -> three frames C,2,8 each followed by 4 zeros; cmd_ready=0 for 21 cycles.
REQ-038 Scenario 4 -- illegal op: op=4'hC -> no frame, err_op=1 next cycle; clr_err and a new illegal op in the same cycle -> err_op stays 1.
REQ-039 Scenario 5 -- drop count: coin_in all lanes 4'h3 during an 8-lane frame -> drop_cnt +8 per busy cycle; preload near 16'hFFFF -> holds at FFFF.
REQ-040 Scenario 6 -- reset mid-frame: rst in OPC -> lane_out=0 the next cycle, IDLE, and cmd_ready=1 on the first cycle after release.
